// File: rtl/mpb_reg_target.sv
// MPB register-bank target: answers each bus request with rdy/rdata after WAIT_CYCLES
// wait states and exposes NUM_REGS read/write registers on a flat output bus.
module mpb_reg_target #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 8,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         vld,
    input  logic                         wr,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic                         rdy,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

    localparam int unsigned IDX_W    = $clog2(NUM_REGS);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    latch_req;
    logic                    req_wr_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic [IDX_W-1:0]        req_idx;
    logic                    req_in_range;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   reg_q [NUM_REGS];

    // Request handling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vld) begin
                    latch_req = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = (WAIT_CYCLES > 0) ? StWait : StAck;
                end
            end
            StWait: begin
                // An abort wins over an expiring counter.
                if (!vld) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (latch_req) begin
            req_wr_q    <= wr;
            req_addr_q  <= addr;
            req_wdata_q <= wdata;
        end
    end

    // Address decode, always from the latched request
    assign req_idx      = req_addr_q[2 +: IDX_W];
    assign req_in_range = (req_addr_q[1:0] == 2'b00) &&
                          ((req_addr_q >> (2 + IDX_W)) == '0);
    assign wr_en        = (state_q == StAck) && req_wr_q && req_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            reg_q[req_idx] <= req_wdata_q;
        end
    end

    // Response
    always_comb begin
        rdy   = 1'b0;
        err   = 1'b0;
        rdata = '0;
        if (state_q == StAck) begin
            rdy = 1'b1;
            err = !req_in_range;
            if (!req_wr_q) begin
                rdata = req_in_range ? reg_q[req_idx] : ERR_RDATA;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
        assign regs[i*DATA_WIDTH +: DATA_WIDTH] = reg_q[i];
    end

endmodule

// File: tb/tb_mpb_reg_target.sv
// Bench for mpb_reg_target: three instances (0, 3 and 5 wait states) each checked every cycle
// against a transaction-level model, plus directed transfers with literal expectations.
module tb_mpb_reg_target;

    localparam int NI = 3;

    logic         clk;
    logic         reset_n [NI];
    logic         vld     [NI];
    logic         wr      [NI];
    logic [31:0]  addr    [NI];
    logic [31:0]  wdata   [NI];
    logic         rdy     [NI];
    logic         err     [NI];
    logic [31:0]  rdata   [NI];
    logic [255:0] regs    [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);

        mpb_reg_target #(
            .WAIT_CYCLES(W)
        ) dut (
            .clk    (clk),
            .reset_n(reset_n[g]),
            .vld    (vld[g]),
            .wr     (wr[g]),
            .addr   (addr[g]),
            .wdata  (wdata[g]),
            .rdy    (rdy[g]),
            .rdata  (rdata[g]),
            .err    (err[g]),
            .regs   (regs[g])
        );

        // Transaction model: a request accepted at edge k is answered in the cycle after edge
        // k+W, commits at the following edge, and is cancelled if vld drops before its answer.
        logic [31:0] m_regs [8];
        bit          busy = 0;
        int          due  = 0;
        int          mc   = 0;
        bit          m_wr;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;

        function automatic bit ok_addr(input logic [31:0] a);
            return (a < 32'd32) && ((a & 32'd3) == 32'd0);
        endfunction

        initial begin
            for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
            forever @(posedge clk) begin
                mc = mc + 1;
                if (!reset_n[g]) begin
                    busy = 0;
                    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
                end else if (busy) begin
                    if (mc == due + 1) begin
                        if (m_wr && ok_addr(m_addr)) m_regs[m_addr / 4] = m_wdata;
                        busy = 0;
                    end else if (!vld[g]) begin
                        busy = 0;
                    end
                end else if (vld[g]) begin
                    busy    = 1;
                    due     = mc + int'(W);
                    m_wr    = wr[g];
                    m_addr  = addr[g];
                    m_wdata = wdata[g];
                end
            end
        end

        initial forever @(negedge clk) begin
            logic         e_rdy;
            logic         e_err;
            logic [31:0]  e_rdata;
            logic [255:0] e_regs;
            e_rdy   = 1'b0;
            e_err   = 1'b0;
            e_rdata = 32'd0;
            e_regs  = '0;
            if (reset_n[g]) begin
                for (int i = 0; i < 8; i++) e_regs[i*32 +: 32] = m_regs[i];
                if (busy && mc == due) begin
                    e_rdy = 1'b1;
                    e_err = !ok_addr(m_addr);
                    if (!m_wr) e_rdata = ok_addr(m_addr) ? m_regs[m_addr / 4] : 32'hDEAD_BEEF;
                end
            end
            chk($sformatf("i%0d rdy", g), rdy[g], e_rdy);
            chk($sformatf("i%0d err", g), err[g], e_err);
            chk($sformatf("i%0d rdata", g), rdata[g], e_rdata);
            chk($sformatf("i%0d regs", g), regs[g], e_regs);
        end
    end

    // Call at a negedge; returns at the negedge of the idle cycle after the acknowledge.
    task automatic xfer(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output logic [31:0] rd, output logic e,
                        output int lat, output int when);
        bit seen;
        seen    = 0;
        rd      = 32'd0;
        e       = 1'b0;
        lat     = 0;
        when    = 0;
        vld[g]  = 1'b1;
        wr[g]   = w;
        addr[g] = a;
        wdata[g] = d;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat = lat + 1;
            if (rdy[g]) begin
                seen = 1;
                rd   = rdata[g];
                e    = err[g];
                when = cyc;
            end
        end
        chk($sformatf("i%0d rdy within budget", g), seen, 1'b1);
        @(negedge clk);
        if (!keep) vld[g] = 1'b0;
    endtask

    initial begin
        logic [31:0]  rd;
        logic         e;
        int           lat;
        int           when;
        int           prev;
        bit           any;
        logic [255:0] exp_regs;

        for (int g = 0; g < NI; g++) begin
            reset_n[g] = 1'b0;
            vld[g]     = 1'b0;
            wr[g]      = 1'b0;
            addr[g]    = 32'd0;
            wdata[g]   = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) reset_n[g] = 1'b1;
        @(negedge clk);
        chk("reset rdy", rdy[0], 1'b0);
        chk("reset err", err[0], 1'b0);
        chk("reset rdata", rdata[0], 32'd0);
        chk("reset regs", regs[0], 256'd0);

        xfer(0, 1'b0, 32'h04, 32'd0, 1'b0, rd, e, lat, when);
        chk("read 0x04 rdata", rd, 32'd0);
        chk("read 0x04 latency", lat, 1);

        xfer(0, 1'b1, 32'h08, 32'h1234_5678, 1'b0, rd, e, lat, when);
        chk("write 0x08 latency", lat, 1);
        chk("write 0x08 err", e, 1'b0);
        chk("write 0x08 rdata", rd, 32'd0);
        chk("regs[2] after write", regs[0][95:64], 32'h1234_5678);
        xfer(0, 1'b0, 32'h08, 32'd0, 1'b0, rd, e, lat, when);
        chk("read 0x08 rdata", rd, 32'h1234_5678);
        chk("read 0x08 latency", lat, 1);

        xfer(1, 1'b0, 32'h00, 32'd0, 1'b0, rd, e, lat, when);
        chk("wait3 latency", lat, 4);
        chk("wait3 rdy single pulse", rdy[1], 1'b0);

        exp_regs        = '0;
        exp_regs[95:64] = 32'h1234_5678;
        xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0, rd, e, lat, when);
        chk("write 0x20 err", e, 1'b1);
        chk("write 0x20 regs unchanged", regs[0], exp_regs);
        xfer(0, 1'b0, 32'h21, 32'd0, 1'b0, rd, e, lat, when);
        chk("read 0x21 rdata", rd, 32'hDEAD_BEEF);
        chk("read 0x21 err", e, 1'b1);
        xfer(0, 1'b0, 32'h4000_0000, 32'd0, 1'b0, rd, e, lat, when);
        chk("read high addr err", e, 1'b1);
        xfer(0, 1'b0, 32'h1C, 32'd0, 1'b0, rd, e, lat, when);
        chk("read 0x1C err", e, 1'b0);
        chk("read 0x1C rdata", rd, 32'd0);

        // Abort in the wait phase
        vld[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h0C; wdata[2] = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        vld[2] = 1'b0;
        any = 0;
        repeat (10) begin
            @(negedge clk);
            any = any | rdy[2];
        end
        chk("abort no rdy", any, 1'b0);
        chk("abort regs[3] unchanged", regs[2][127:96], 32'd0);

        xfer(2, 1'b1, 32'h0C, 32'h0F0F_0F0F, 1'b0, rd, e, lat, when);
        chk("wait5 latency", lat, 6);
        chk("wait5 regs[3]", regs[2][127:96], 32'h0F0F_0F0F);

        // Reset pulse during the wait phase
        vld[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h0C; wdata[2] = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        #1;
        reset_n[2] = 1'b0;
        vld[2]     = 1'b0;
        #1;
        chk("reset in wait rdy", rdy[2], 1'b0);
        chk("reset in wait regs", regs[2], 256'd0);
        @(negedge clk);
        reset_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        chk("after reset regs[3]", regs[2][127:96], 32'd0);

        // Back-to-back writes with vld held high
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), (i < 7), rd, e, lat, when);
            if (i > 0) chk($sformatf("b2b spacing %0d", i), when - prev, 2);
            prev = when;
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 32'd0, 1'b0, rd, e, lat, when);
            chk($sformatf("b2b readback %0d", i), rd, 32'hC0DE_0000 + 32'(i));
        end

        // Reset pulse while the acknowledge is on the bus
        xfer(1, 1'b1, 32'h04, 32'h0000_55AA, 1'b0, rd, e, lat, when);
        vld[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h04;
        any = 0;
        for (int i = 0; i < 20 && !any; i++) begin
            @(negedge clk);
            any = rdy[1];
        end
        chk("ack seen before reset", any, 1'b1);
        chk("ack rdata before reset", rdata[1], 32'h0000_55AA);
        #1;
        reset_n[1] = 1'b0;
        vld[1]     = 1'b0;
        #1;
        chk("reset in ack rdy", rdy[1], 1'b0);
        chk("reset in ack rdata", rdata[1], 32'd0);
        chk("reset in ack regs", regs[1], 256'd0);
        @(negedge clk);
        reset_n[1] = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
